frog_motion: RTL

Frog position and direction controller. It sits directly upstream of the frog sprite renderer and drives that renderer's `frog_x`, `frog_y` and `direction` inputs. It debounces the four push buttons and turns each press into one 32-pixel hop, animated over several video frames. It also blocks moves that would leave the screen, and handles the death/respawn sequence when the lane logic reports a collision. Position changes only on `frame_tick`, so the renderer never sees coordinates change mid-frame.

---
 rtl/frog_motion.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/frog_motion.sv
// Frog position/direction controller: debounced buttons become 32-pixel hops
// animated over several frames, with edge-of-screen blocking and death/respawn.
module frog_motion #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int FROG_SIZE       = 32,
  parameter int HOP_STEP        = 4,
  parameter int HOP_FRAMES      = 8,
  parameter int DEATH_FRAMES    = 60,
  parameter int START_X         = 304,
  parameter int START_Y         = 448,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       collision,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] direction,
  output logic       hopping,
  output logic       dead
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FMAX = (HOP_FRAMES > DEATH_FRAMES) ? HOP_FRAMES : DEATH_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOP  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  // Bit order doubles as priority order within one cycle: up > down > left > right.
  logic [3:0]     btn_raw;
  logic [3:0]     sync_a;
  logic [3:0]     sync_b;
  logic [3:0]     deb;
  logic [3:0]     rise;
  logic [DBW-1:0] db_cnt [4];

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rise[i] = sync_b[i] && !deb[i] && (db_cnt[i] == DB_LAST);
    end
  end

  logic [1:0] rise_dir;

  always_comb begin
    rise_dir = DIR_RIGHT;
    if (rise[0])      rise_dir = DIR_UP;
    else if (rise[1]) rise_dir = DIR_DOWN;
    else if (rise[2]) rise_dir = DIR_LEFT;
  end

  logic       pend_vld;
  logic [1:0] pend_dir;
  logic       pend_clr;

  // A fresh edge beats a same-cycle clear, so a tick never swallows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_dir <= DIR_UP;
    end else if (|rise) begin
      pend_vld <= 1'b1;
      pend_dir <= rise_dir;
    end else if (pend_clr) begin
      pend_vld <= 1'b0;
    end
  end

  logic up_ok;
  logic down_ok;
  logic left_ok;
  logic right_ok;
  logic move_ok;

  assign up_ok    = {1'b0, frog_y} >= 11'(FROG_SIZE);
  assign down_ok  = ({1'b0, frog_y} + 11'(2 * FROG_SIZE)) <= 11'(SCREEN_H);
  assign left_ok  = {1'b0, frog_x} >= 11'(FROG_SIZE);
  assign right_ok = ({1'b0, frog_x} + 11'(2 * FROG_SIZE)) <= 11'(SCREEN_W);

  always_comb begin
    case (pend_dir)
      DIR_UP:    move_ok = up_ok;
      DIR_RIGHT: move_ok = right_ok;
      DIR_DOWN:  move_ok = down_ok;
      default:   move_ok = left_ok;
    endcase
  end

  state_t         state;
  state_t         state_nxt;
  logic [FCW-1:0] fcnt;
  logic [FCW-1:0] fcnt_nxt;
  logic [FCW-1:0] fcnt_inc;
  logic [9:0]     x_nxt;
  logic [9:0]     y_nxt;
  logic [1:0]     dir_nxt;
  logic [1:0]     move_dir;
  logic           move;

  assign fcnt_inc = fcnt + FCW'(1);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    x_nxt     = frog_x;
    y_nxt     = frog_y;
    dir_nxt   = direction;
    move_dir  = direction;
    move      = 1'b0;
    pend_clr  = 1'b0;

    if (frame_tick) begin
      if (collision && state != S_DEAD) begin
        state_nxt = S_DEAD;
        fcnt_nxt  = '0;
        pend_clr  = 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (pend_vld) begin
              dir_nxt  = pend_dir;
              pend_clr = 1'b1;
              if (move_ok) begin
                state_nxt = S_HOP;
                move      = 1'b1;
                move_dir  = pend_dir;
                fcnt_nxt  = FCW'(1);
              end
            end
          end
          S_HOP: begin
            move     = 1'b1;
            pend_clr = 1'b1;
            fcnt_nxt = fcnt_inc;
            if (fcnt_inc == FCW'(HOP_FRAMES)) state_nxt = S_IDLE;
          end
          S_DEAD: begin
            pend_clr = 1'b1;
            fcnt_nxt = fcnt_inc;
            if (fcnt_inc == FCW'(DEATH_FRAMES)) begin
              state_nxt = S_IDLE;
              x_nxt     = 10'(START_X);
              y_nxt     = 10'(START_Y);
              dir_nxt   = DIR_UP;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end

    if (move) begin
      case (move_dir)
        DIR_UP:    y_nxt = frog_y - 10'(HOP_STEP);
        DIR_RIGHT: x_nxt = frog_x + 10'(HOP_STEP);
        DIR_DOWN:  y_nxt = frog_y + 10'(HOP_STEP);
        default:   x_nxt = frog_x - 10'(HOP_STEP);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fcnt      <= '0;
      frog_x    <= 10'(START_X);
      frog_y    <= 10'(START_Y);
      direction <= DIR_UP;
      hopping   <= 1'b0;
      dead      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fcnt      <= fcnt_nxt;
      frog_x    <= x_nxt;
      frog_y    <= y_nxt;
      direction <= dir_nxt;
      hopping   <= (state_nxt == S_HOP);
      dead      <= (state_nxt == S_DEAD);
    end
  end

endmodule
